// File: rtl/cpu_chan_pkg.sv
// Register channel IDs and implicit-y2 encodings shared by the interlock and the bypass network.
package cpu_chan_pkg;

    localparam int CH_W = 4;

    localparam logic [CH_W-1:0] CH_NONE = 4'd0;
    localparam logic [CH_W-1:0] CH_FLAG = 4'd9;
    localparam logic [CH_W-1:0] CH_SP   = 4'd13;
    localparam logic [CH_W-1:0] CH_TLB  = 4'd14;

    typedef enum logic [1:0] {
        Y2_NONE = 2'd0,
        Y2_FLAG = 2'd1,
        Y2_SP   = 2'd2,
        Y2_RSVD = 2'd3
    } y2_sel_e;

    // Reserved encoding behaves as "no implicit write".
    function automatic logic [CH_W-1:0] y2_target(input logic [1:0] sel);
        case (sel)
            Y2_FLAG: return CH_FLAG;
            Y2_SP:   return CH_SP;
            default: return CH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One scoreboard slot: cycles remaining until the channel's result is forwardable.
// Latency: load visible next cycle; backpressure: dec_en low freezes the count.
module sb_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             nz
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = load_val;
        end else if (dec_en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz = (cnt_q != '0);

endmodule

// File: rtl/bypass_interlock_ctrl.sv
// Scoreboard interlock: stalls operand fetch while a source/dest channel awaits a late result.
// Latency: stall/accept combinational from the presented instruction; loads take effect next cycle.
// Backpressure: pipe_hold freezes all counters and forces stall; INTERLOCK_PERF_EN adds stall_cycles.
module bypass_interlock_ctrl
    import cpu_chan_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int Y2_LAT = 0,
    parameter int NUM_CH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [CH_W-1:0]   issue_x1_ch,
    input  logic [CH_W-1:0]   issue_x2_ch,
    input  logic [CH_W-1:0]   issue_dst_ch,
    input  logic [CNT_W-1:0]  issue_lat,
    input  logic [1:0]        issue_y2_sel,
    input  logic              cfg_no_fwd14,
    input  logic              pipe_hold,
    input  logic              flush,
    output logic              stall,
    output logic              issue_accept,
    output logic [NUM_CH-1:0] pending
`ifdef INTERLOCK_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] Y2_C = CNT_W'(Y2_LAT);

    logic [NUM_CH-1:0] pend_nz;
    logic [CH_W-1:0]   y2_ch;
    logic              haz;
    logic [CNT_W-1:0]  eff_lat;
    logic [NUM_CH-1:1] load_en;
    logic [CNT_W-1:0]  load_val [1:NUM_CH-1];

    assign pend_nz[0] = 1'b0;
    assign y2_ch      = y2_target(issue_y2_sel);

    // Channel 0 reads as never busy, so "none" operands drop out of the test.
    assign haz = pend_nz[issue_x1_ch] | pend_nz[issue_x2_ch]
               | pend_nz[issue_dst_ch] | pend_nz[y2_ch];

    // Outputs are gated by rst_n so nothing can be accepted while reset is held.
    assign stall        = rst_n & issue_valid & (haz | pipe_hold);
    assign issue_accept = rst_n & issue_valid & ~stall & ~flush;
    assign pending      = pend_nz;

    always_comb begin
        eff_lat = issue_lat;
        if (issue_dst_ch == CH_TLB && cfg_no_fwd14 && issue_lat == '0) begin
            eff_lat = CNT_W'(1);
        end
    end

    // When y1 and y2 target the same channel the longer wait wins.
    always_comb begin
        for (int n = 1; n < NUM_CH; n++) begin
            load_en[n] = issue_accept &
                         ((issue_dst_ch == CH_W'(n)) | (y2_ch == CH_W'(n)));
            if (issue_dst_ch == CH_W'(n) && (y2_ch != CH_W'(n) || eff_lat > Y2_C)) begin
                load_val[n] = eff_lat;
            end else begin
                load_val[n] = Y2_C;
            end
        end
    end

    for (genvar n = 1; n < NUM_CH; n++) begin : g_ch
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en[n]),
            .load_val (load_val[n]),
            .dec_en   (~pipe_hold),
            .nz       (pend_nz[n])
        );
    end

`ifdef INTERLOCK_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'b0, stall & ~pipe_hold};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_bypass_interlock_ctrl.sv
// Bench for bypass_interlock_ctrl: directed vector table, async-reset sequence, randomized model check.
module tb_bypass_interlock_ctrl;

    localparam int CNT_W  = 3;
    localparam int Y2_LAT = 2;
    localparam int NUM_CH = 16;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic [3:0]        issue_x1_ch;
    logic [3:0]        issue_x2_ch;
    logic [3:0]        issue_dst_ch;
    logic [CNT_W-1:0]  issue_lat;
    logic [1:0]        issue_y2_sel;
    logic              cfg_no_fwd14;
    logic              pipe_hold;
    logic              flush;
    logic              stall;
    logic              issue_accept;
    logic [NUM_CH-1:0] pending;
`ifdef INTERLOCK_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    bypass_interlock_ctrl #(
        .CNT_W  (CNT_W),
        .Y2_LAT (Y2_LAT),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_x1_ch  (issue_x1_ch),
        .issue_x2_ch  (issue_x2_ch),
        .issue_dst_ch (issue_dst_ch),
        .issue_lat    (issue_lat),
        .issue_y2_sel (issue_y2_sel),
        .cfg_no_fwd14 (cfg_no_fwd14),
        .pipe_hold    (pipe_hold),
        .flush        (flush),
        .stall        (stall),
        .issue_accept (issue_accept),
        .pending      (pending)
`ifdef INTERLOCK_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] x1, x2, dst;
        logic [2:0] lat;
        logic [1:0] y2;
        logic       cfg, hold, fl;
        logic       e_stall, e_acc;
        logic [15:0] e_pend;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: cycles remaining before each channel's result is forwardable.
    int   m_cnt [16];
    int   m_perf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] x1, input logic [3:0] x2,
                                input logic [3:0] dst, input logic [2:0] lat, input logic [1:0] y2,
                                input logic cfg, input logic hold, input logic fl,
                                input logic es, input logic ea, input logic [15:0] ep);
        vec_t r;
        r.v = v; r.x1 = x1; r.x2 = x2; r.dst = dst; r.lat = lat; r.y2 = y2;
        r.cfg = cfg; r.hold = hold; r.fl = fl;
        r.e_stall = es; r.e_acc = ea; r.e_pend = ep;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        issue_valid  = r.v;
        issue_x1_ch  = r.x1;
        issue_x2_ch  = r.x2;
        issue_dst_ch = r.dst;
        issue_lat    = r.lat;
        issue_y2_sel = r.y2;
        cfg_no_fwd14 = r.cfg;
        pipe_hold    = r.hold;
        flush        = r.fl;
    endtask

    function automatic bit m_busy(input int ch);
        return ch != 0 && m_cnt[ch] > 0;
    endfunction

    function automatic int m_y2(input int sel);
        return (sel == 1) ? 9 : (sel == 2) ? 13 : 0;
    endfunction

    task automatic model_eval(output bit ms, output bit ma);
        bit h;
        h  = m_busy(int'(issue_x1_ch)) || m_busy(int'(issue_x2_ch)) ||
             m_busy(int'(issue_dst_ch)) || m_busy(m_y2(int'(issue_y2_sel)));
        ms = issue_valid && (h || pipe_hold);
        ma = issue_valid && !ms && !flush;
    endtask

    task automatic model_update(input bit ma);
        int dst, y2t, eff;
        if (!pipe_hold) begin
            for (int c = 1; c < 16; c++) if (m_cnt[c] > 0) m_cnt[c]--;
        end
        if (ma) begin
            dst = int'(issue_dst_ch);
            y2t = m_y2(int'(issue_y2_sel));
            eff = int'(issue_lat);
            if (dst == 14 && cfg_no_fwd14 && eff == 0) eff = 1;
            if (dst != 0) m_cnt[dst] = eff;
            if (y2t != 0) m_cnt[y2t] = (dst == y2t && eff > Y2_LAT) ? eff : Y2_LAT;
        end
    endtask

    function automatic logic [15:0] m_pend();
        logic [15:0] p;
        p = '0;
        for (int c = 1; c < 16; c++) p[c] = (m_cnt[c] > 0);
        return p;
    endfunction

    initial begin
        bit ms, ma;
        vec_t r;

        // v  x1 x2 dst lat y2 cfg hold fl | stall acc pend
        tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0002));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0002));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 14, 0, 0, 1, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h4000));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 14, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0200));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0200));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 5, 3, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0020));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0020));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0020));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0020));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 6, 4, 0, 0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0040));
        tbl.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0040));
        tbl.push_back(mk(1, 0, 0, 7, 5, 0, 0, 0, 0, 0, 1, 16'h0040));
        tbl.push_back(mk(1, 7, 7, 7, 1, 0, 0, 0, 0, 1, 0, 16'h00C0));

        // Reset held with an instruction presented: nothing may stall or be accepted.
        rst_n = 1'b0;
        drive(mk(1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 16'h0000));
        #3;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_accept", {31'b0, issue_accept}, 32'd0);
        chk("rst_pending", {16'b0, pending}, 32'd0);
        issue_valid = 1'b0;
        pipe_hold   = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            r = tbl[i];
            drive(r);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, r.e_stall});
            chk($sformatf("vec%0d_accept", i), {31'b0, issue_accept}, {31'b0, r.e_acc});
            chk($sformatf("vec%0d_pending", i), {16'b0, pending}, {16'b0, r.e_pend});
            @(posedge clk); #1;
        end

        // Async reset mid-count: ch7 still has 4 cycles to go.
        drive(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'd1);
        chk("pre_rst_pending", {16'b0, pending}, 32'h0080);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pending", {16'b0, pending}, 32'd0);
        chk("async_rst_stall", {31'b0, stall}, 32'd0);
        chk("async_rst_accept", {31'b0, issue_accept}, 32'd0);
        issue_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) m_cnt[c] = 0;
        m_perf = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            issue_valid  = ($urandom_range(0, 9) < 8);
            issue_x1_ch  = 4'($urandom_range(0, 15));
            issue_x2_ch  = 4'($urandom_range(0, 15));
            issue_dst_ch = 4'($urandom_range(0, 15));
            issue_lat    = 3'($urandom_range(0, 7));
            issue_y2_sel = 2'($urandom_range(0, 3));
            cfg_no_fwd14 = 1'($urandom_range(0, 1));
            pipe_hold    = ($urandom_range(0, 99) < 15);
            flush        = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            model_eval(ms, ma);
            chk("rnd_stall", {31'b0, stall}, {31'b0, ms});
            chk("rnd_accept", {31'b0, issue_accept}, {31'b0, ma});
            chk("rnd_pending", {16'b0, pending}, {16'b0, m_pend()});
            if (ms && !pipe_hold) m_perf++;
            model_update(ma);
            @(posedge clk); #1;
        end

`ifdef INTERLOCK_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_perf));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bypass_interlock_ctrl.md
Name: bypass_interlock_ctrl

Overview:
- Scoreboard and interlock controller in front of the operand-forwarding network.
- The bypass covers results that are available at the end of execute. This block tracks destinations whose results arrive later: memory loads, multi-cycle mul/div, and channel 14 when its forwarding is disabled.
- It stalls the operand-fetch stage until the pending result can be forwarded or has been written back.
- Sits between decode/operand-fetch and execute, using the same 4-bit register channel IDs. Channel 0 means none.

Parameters:
- CNT_W, 3, width of each per-channel pending counter. Maximum latency is 2^CNT_W-1.
- Y2_LAT, 0, extra latency applied to implicit y2 writes (flag or sp).
- NUM_CH, 16, number of channel IDs. Channel 0 is never tracked.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  operand-fetch stage holds an instruction
- issue_x1_ch  in  4  source channel of operand x1
- issue_x2_ch  in  4  source channel of operand x2
- issue_dst_ch  in  4  y1 destination channel (0 = none)
- issue_lat  in  CNT_W  cycles after execute before y1 can be forwarded (0 = forwardable from execute)
- issue_y2_sel  in  2  implicit y2 write: 0 none, 1 flag (ch 9), 2 sp (ch 13), 3 reserved/none
- cfg_no_fwd14  in  1  forwarding of channel 14 disabled (sys_info[2])
- pipe_hold  in  1  downstream memory wait; freezes all counters
- flush  in  1  pipeline flush (branch/interrupt)
- stall  out  1  hold operand-fetch, inject bubble into execute
- issue_accept  out  1  instruction advances to execute this cycle
- pending  out  NUM_CH  bit n = counter n nonzero; bit 0 always 0

Behaviour:
- Reset state:
  - All counters are 0.
  - stall=0, issue_accept=0, pending=0.
  - The reset is asynchronous, and all registers are cleared immediately.
- Hazard test (combinational):
  - haz = cnt[x1]!=0 | cnt[x2]!=0 | cnt[dst]!=0 | (y2 target counter !=0).
  - The dst term is the WAW check.
  - Any term whose channel is 0 is ignored.
- Outputs:
  - stall = issue_valid & (haz | pipe_hold).
  - issue_accept = issue_valid & ~stall & ~flush.
- Counter load on issue_accept:
  - cnt[dst] <= eff_lat, where eff_lat = issue_lat, except when dst==14 and cfg_no_fwd14, where eff_lat = max(issue_lat,1).
  - If y2_sel is 1 or 2, cnt[9 or 13] <= Y2_LAT.
  - A load takes priority over the decrement for the same channel in the same cycle.
- Counter decrement: every cycle with pipe_hold=0, each nonzero counter that is not being loaded decrements by 1. Counters saturate at 0.
- pipe_hold=1:
  - Counters hold.
  - A counter load on issue_accept is not possible, since accept is forced low.
- flush=1:
  - Counters are not cleared. In-flight older instructions still complete.
  - The presented instruction is not accepted.
- Latency: a consumer issued k cycles after a producer with lat L stalls for max(0, L-k+1) cycles. After that, the bypass supplies the data.
- x1==x2==dst on the same channel is legal and evaluated once.
- issue_lat wider than the counter cannot occur, because widths match.
- Reset while counters are nonzero returns the block to the idle state.

Optional Feature:
- Macro: INTERLOCK_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - The counter increments on each cycle with stall=1 and pipe_hold=0, and wraps at 2^32.
  - It is cleared by rst_n only.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_chan_pkg holds:
  - CH_NONE=0, CH_FLAG=9, CH_SP=13, CH_TLB=14, CH_W=4.
  - The y2_sel encodings.
  - The same constants are reused by the bypass network.
- Sub-module sb_counter: one CNT_W down-counter with load/hold/nonzero flag, instantiated NUM_CH-1 times.

Test Plan:
- Reset, then issue of ch1 with lat=2.
  - Response: accept in cycle 0, pending[1]=1.
  - A consumer of x1=1 in cycle 1 stalls 2 cycles, then is accepted in cycle 3.
- Back-to-back ALU ops: dst=3 lat=0, then x2=3.
  - Response: no stall, pending stays 0.
- cfg_no_fwd14=1, dst=14 lat=0, then x1=14.
  - Response: one stall cycle. With cfg=0 there are zero stalls.
- y2_sel=1 with Y2_LAT=2, then x1=9.
  - Response: stall 2 cycles, then accept.
- Load dst=5 lat=3, pipe_hold asserted 4 cycles mid-count, then x1=5.
  - Response: counter frozen while held, total stall = 3 + 4 cycles.
- Flush with a pending hazard, followed by async reset mid-count.
  - Response: flush blocks accept but pending holds. The reset drops pending to 0 and stall to 0 immediately.
